// File: rtl/memory_controller.sv
// memory_controller: arbitrates instruction fetch and the load/store buffer onto a
// single byte-wide RAM port. Accesses of 1/2/4 bytes are serialised little-endian.
// Optional feature macro: MC_IO_STALL_EN (stall stores to the I/O range while the
// UART buffer is full). Without it io_buffer_full is ignored.
module memory_controller #(
  parameter int         ADDR_W = 32,
  parameter logic [1:0] IO_SEL = 2'b11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              flush,
  input  logic [7:0]        mem_din,
  output logic [7:0]        mem_dout,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_wr,
  input  logic              io_buffer_full,
  input  logic              if_valid,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_done,
  output logic [31:0]       if_data,
  input  logic              lsb_valid,
  input  logic              lsb_ls,
  input  logic [5:0]        lsb_opcode,
  input  logic [ADDR_W-1:0] lsb_addr,
  input  logic [31:0]       lsb_s_data,
  output logic              lsb_done,
  output logic [31:0]       lsb_l_data
);

  localparam logic [5:0] OP_LB  = 6'd0;
  localparam logic [5:0] OP_LH  = 6'd1;
  localparam logic [5:0] OP_LW  = 6'd2;
  localparam logic [5:0] OP_LBU = 6'd3;
  localparam logic [5:0] OP_LHU = 6'd4;
  localparam logic [5:0] OP_SB  = 6'd5;
  localparam logic [5:0] OP_SH  = 6'd6;
  localparam logic [5:0] OP_SW  = 6'd7;

  typedef enum logic [1:0] {IDLE, READ, WRITE, COOLDOWN} state_t;

  function automatic logic [2:0] op_size(input logic [5:0] op);
    case (op)
      OP_LB, OP_LBU, OP_SB: op_size = 3'd1;
      OP_LH, OP_LHU, OP_SH: op_size = 3'd2;
      OP_LW, OP_SW:         op_size = 3'd4;
      default:              op_size = 3'd4;
    endcase
  endfunction

  function automatic logic [31:0] extend(input logic [5:0] op, input logic [31:0] w);
    case (op)
      OP_LB:   extend = {{24{w[7]}}, w[7:0]};
      OP_LH:   extend = {{16{w[15]}}, w[15:0]};
      OP_LBU:  extend = {24'b0, w[7:0]};
      OP_LHU:  extend = {16'b0, w[15:0]};
      default: extend = w;
    endcase
  endfunction

  state_t              state_q, state_d;
  logic [2:0]          cnt_q, cnt_d;
  logic [2:0]          size_q, size_d;
  logic                rr_q, rr_d;
  logic                owner_lsb_q, owner_lsb_d;
  logic                flushed_q, flushed_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         sdata_q, sdata_d;
  logic [5:0]          op_q, op_d;
  logic [31:0]         word_q, word_d;
  logic [ADDR_W-1:0]   mem_a_q, mem_a_d;
  logic                mem_wr_q, mem_wr_d;
  logic [7:0]          mem_dout_q, mem_dout_d;
  logic                if_done_q, if_done_d;
  logic [31:0]         if_data_q, if_data_d;
  logic                lsb_done_q, lsb_done_d;
  logic [31:0]         lsb_l_data_q, lsb_l_data_d;

  logic                take_lsb;
  logic                acc_stall;
  logic                wr_stall;
  logic [2:0]          cnt_inc;
  logic [1:0]          rd_idx;
  logic                unused_ok;

  assign unused_ok = &{1'b0, io_buffer_full, IO_SEL};

  // Next-state, datapath and output computation; rdy=0 leaves every register unchanged.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    size_d       = size_q;
    rr_d         = rr_q;
    owner_lsb_d  = owner_lsb_q;
    flushed_d    = flushed_q;
    addr_d       = addr_q;
    sdata_d      = sdata_q;
    op_d         = op_q;
    word_d       = word_q;
    mem_a_d      = mem_a_q;
    mem_wr_d     = mem_wr_q;
    mem_dout_d   = mem_dout_q;
    if_done_d    = if_done_q;
    if_data_d    = if_data_q;
    lsb_done_d   = lsb_done_q;
    lsb_l_data_d = lsb_l_data_q;
    take_lsb     = lsb_valid && (!if_valid || !rr_q);
    cnt_inc      = cnt_q + 3'd1;
    rd_idx       = 2'(cnt_q - 3'd1);
`ifdef MC_IO_STALL_EN
    acc_stall    = (lsb_addr[17:16] == IO_SEL) && io_buffer_full;
    wr_stall     = (addr_q[17:16] == IO_SEL) && io_buffer_full;
`else
    acc_stall    = 1'b0;
    wr_stall     = 1'b0;
`endif
    if (rdy) begin
      case (state_q)
        IDLE: begin
          if_done_d  = 1'b0;
          lsb_done_d = 1'b0;
          // flush on the same edge as a request suppresses the accept
          if (!flush && (if_valid || lsb_valid)) begin
            rr_d        = take_lsb;
            owner_lsb_d = take_lsb;
            cnt_d       = 3'd0;
            flushed_d   = 1'b0;
            word_d      = 32'b0;
            if (take_lsb) begin
              addr_d  = lsb_addr;
              sdata_d = lsb_s_data;
              op_d    = lsb_opcode;
              size_d  = op_size(lsb_opcode);
              mem_a_d = lsb_addr;
            end else begin
              addr_d  = if_addr;
              op_d    = OP_LW;
              size_d  = 3'd4;
              mem_a_d = if_addr;
            end
            if (take_lsb && !lsb_ls) begin
              state_d    = WRITE;
              mem_wr_d   = !acc_stall;
              mem_dout_d = lsb_s_data[7:0];
            end else begin
              state_d  = READ;
              mem_wr_d = 1'b0;
            end
          end
        end
        READ: begin
          if (flush) begin
            state_d = IDLE;
          end else begin
            cnt_d = cnt_inc;
            if (cnt_inc < size_q) mem_a_d = addr_q + ADDR_W'(cnt_inc);
            // mem_din lags the address by one cycle, so byte k arrives two edges after it was addressed
            if (cnt_q != 3'd0) word_d[{rd_idx, 3'b000} +: 8] = mem_din;
            if (cnt_q == size_q) begin
              state_d = COOLDOWN;
              if (owner_lsb_q) begin
                lsb_done_d   = 1'b1;
                lsb_l_data_d = extend(op_q, word_d);
              end else begin
                if_done_d = 1'b1;
                if_data_d = word_d;
              end
            end
          end
        end
        WRITE: begin
          // a flushed store is still completed on the bus, only its done pulse is dropped
          if (flush) flushed_d = 1'b1;
          if (mem_wr_q) begin
            if (cnt_inc == size_q) begin
              mem_wr_d   = 1'b0;
              state_d    = COOLDOWN;
              lsb_done_d = !(flushed_q || flush);
            end else begin
              cnt_d      = cnt_inc;
              mem_a_d    = addr_q + ADDR_W'(cnt_inc);
              mem_dout_d = sdata_q[{cnt_inc[1:0], 3'b000} +: 8];
              mem_wr_d   = !wr_stall;
            end
          end else if (!wr_stall) begin
            mem_wr_d = 1'b1;
          end
        end
        default: begin
          state_d    = IDLE;
          if_done_d  = 1'b0;
          lsb_done_d = 1'b0;
        end
      endcase
    end
  end

  // State register with synchronous reset; reset drops any access in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= 3'd0;
      size_q       <= 3'd0;
      rr_q         <= 1'b0;
      owner_lsb_q  <= 1'b0;
      flushed_q    <= 1'b0;
      addr_q       <= '0;
      sdata_q      <= 32'b0;
      op_q         <= 6'd0;
      word_q       <= 32'b0;
      mem_a_q      <= '0;
      mem_wr_q     <= 1'b0;
      mem_dout_q   <= 8'd0;
      if_done_q    <= 1'b0;
      if_data_q    <= 32'b0;
      lsb_done_q   <= 1'b0;
      lsb_l_data_q <= 32'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      size_q       <= size_d;
      rr_q         <= rr_d;
      owner_lsb_q  <= owner_lsb_d;
      flushed_q    <= flushed_d;
      addr_q       <= addr_d;
      sdata_q      <= sdata_d;
      op_q         <= op_d;
      word_q       <= word_d;
      mem_a_q      <= mem_a_d;
      mem_wr_q     <= mem_wr_d;
      mem_dout_q   <= mem_dout_d;
      if_done_q    <= if_done_d;
      if_data_q    <= if_data_d;
      lsb_done_q   <= lsb_done_d;
      lsb_l_data_q <= lsb_l_data_d;
    end
  end

  assign mem_a      = mem_a_q;
  assign mem_wr     = mem_wr_q;
  assign mem_dout   = mem_dout_q;
  assign if_done    = if_done_q;
  assign if_data    = if_data_q;
  assign lsb_done   = lsb_done_q;
  assign lsb_l_data = lsb_l_data_q;

endmodule
